sync_4bit_up_counter: RTL
=========================

SYNC_4BIT_UP_COUNTER -- requirements
Module: sync_4bit_up_counter

Interface
REQ-001 Parameter MOD, default 16, SHALL set the count modulus; legal range 2..16; count sequence is 0..MOD-1.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset, sampled on rising clk.
REQ-004 en  input  1  SHALL be the count enable; count advances only when high.
REQ-005 load  input  1  SHALL be the synchronous parallel-load strobe.
REQ-006 load_val  input  4  SHALL be the value captured when load is high.
REQ-007 clr_err  input  1  SHALL be the synchronous clear for sticky flags.
REQ-008 Q  output  4  SHALL be the registered count value.
REQ-009 Q_bar  output  4  SHALL be the bitwise complement of Q at all times.
REQ-010 tc  output  1  SHALL be terminal count: combinational, high when en=1, load=0, rst=0 and Q=MOD-1.
REQ-011 ovf  output  1  SHALL be a sticky rollover flag, registered.
REQ-012 load_err  output  1  SHALL be a sticky illegal-load flag, registered.

Function
REQ-013 Per-edge priority SHALL be: rst > load > en > hold.
REQ-014 load=1: if load_val < MOD, Q SHALL take load_val on the next edge, regardless of en.
REQ-015 load=1 with load_val >= MOD: Q SHALL take 0 and load_err SHALL set on the same edge.
REQ-016 en=1, load=0, Q < MOD-1: Q SHALL increment by 1 on the next edge (latency one cycle).
REQ-017 en=1, load=0, Q = MOD-1: Q SHALL wrap to 0 and ovf SHALL set on the same edge.
REQ-018 en=0, load=0: Q, ovf and load_err SHALL hold.
REQ-019 Q SHALL never hold a value >= MOD after the first edge following reset.
REQ-020 clr_err=1 SHALL clear ovf and load_err on the next edge, except when the same edge sets a flag; setting SHALL win over clearing.
REQ-021 clr_err SHALL NOT affect Q.
REQ-022 tc SHALL be usable as en of a cascaded next-stage counter on the same clk; cascaded stages SHALL form a synchronous multi-digit up counter with no ripple delay.
REQ-023 MOD=16: wrap SHALL occur from 4'hF to 4'h0; load_err SHALL never set.
REQ-024 Simultaneous load=1 and en=1: load SHALL win; no increment; ovf SHALL NOT set even if Q=MOD-1.

Reset
REQ-025 rst=1 on a rising edge SHALL force Q=4'h0, Q_bar=4'hF, ovf=0, load_err=0, overriding load, en and clr_err.
REQ-026 During rst=1, tc SHALL be 0.
REQ-027 Deasserting rst mid-sequence SHALL restart counting from 0 on the first enabled edge after release; no prior state SHALL survive.
REQ-028 Before the first reset edge, output values are undefined; benches SHALL apply rst for at least one edge.

Verification
REQ-029 MOD=16, rst one cycle, en=1 for 17 cycles -> Q steps 0,1..15,0,1; tc high exactly while Q=15; ovf sets at the 15->0 edge and stays 1.
REQ-030 MOD=10, load=1 load_val=7, then en=1 for 4 cycles -> Q=7,8,9,0,1; ovf=1 after the 9->0 edge; load_err=0.
REQ-031 MOD=10, load=1 load_val=12 -> Q=0, load_err=1; then clr_err=1 one cycle -> load_err=0, Q unchanged.
REQ-032 MOD=16, Q=15, load=1 load_val=3 and en=1 same cycle -> Q=3, ovf unchanged, tc=0 that cycle.
REQ-033 Q=5 counting, rst=1 one cycle with load=1 load_val=9 and en=1 -> Q=0, Q_bar=4'hF, both flags 0; next enabled edge Q=1.
REQ-034 Two MOD=10 instances, stage1.en=stage0.tc, en=1 for 25 cycles from reset -> {stage1,stage0}=2,5; stage1 increments only on stage0 9->0 edges.

Source files
------------

// File: rtl/sync_4bit_up_counter.sv
// Modulo-MOD 4-bit synchronous up counter with load, sticky flags, cascade tc.
// Ports: clk, rst, en, load, load_val[3:0], clr_err in; Q, Q_bar, tc, ovf, load_err out.
module sync_4bit_up_counter #(
  parameter int MOD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       clr_err,
  output logic [3:0] Q,
  output logic [3:0] Q_bar,
  output logic       tc,
  output logic       ovf,
  output logic       load_err
);

  localparam logic [3:0] LAST = 4'(MOD - 1);
  localparam logic [4:0] MODW = 5'(MOD);

  logic [3:0] q_q, q_d;
  logic       ovf_q, ovf_d;
  logic       lerr_q, lerr_d;
  logic       at_last;
  logic       val_ok;
  logic       wrap;
  logic       bad_ld;

  assign at_last = (q_q == LAST);
  // widen so MOD=16 compares correctly
  assign val_ok  = ({1'b0, load_val} < MODW);

  always_comb begin
    q_d    = q_q;
    wrap   = 1'b0;
    bad_ld = 1'b0;
    if (load) begin
      if (val_ok) begin
        q_d = load_val;
      end else begin
        q_d    = 4'h0;
        bad_ld = 1'b1;
      end
    end else if (en) begin
      if (at_last) begin
        q_d  = 4'h0;
        wrap = 1'b1;
      end else begin
        q_d = q_q + 4'd1;
      end
    end
  end

  // a flag being set on this edge beats a clear request
  always_comb begin
    ovf_d  = ovf_q;
    lerr_d = lerr_q;
    if (clr_err) begin
      ovf_d  = 1'b0;
      lerr_d = 1'b0;
    end
    if (wrap) begin
      ovf_d = 1'b1;
    end
    if (bad_ld) begin
      lerr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= 4'h0;
      ovf_q  <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      ovf_q  <= ovf_d;
      lerr_q <= lerr_d;
    end
  end

  assign Q        = q_q;
  assign Q_bar    = ~q_q;
  // combinational so a next stage can use it as its enable
  assign tc       = en & ~load & ~rst & at_last;
  assign ovf      = ovf_q;
  assign load_err = lerr_q;

endmodule
